// File: rtl/conv1_pkg.sv
// ----------------------------------------------------------------------------
// conv1_pkg
// Shared types and constants for the conv1 PE-chain sequencer.
//   state_t   : sequencer states
//   KROWS     : kernel rows (= PEs in the chain)
//   PSUM_W    : width of the partial sum leaving the last PE
//   PIX_W     : width of one pixel / weight byte
//   due_step  : advance index at which the result for window start j is
//               visible on the last PE's psum output
// ----------------------------------------------------------------------------
package conv1_pkg;

  localparam int KROWS  = 3;
  localparam int PSUM_W = 20;
  localparam int PIX_W  = 8;
  localparam int KROW_W = KROWS * PIX_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_W,
    S_RUN,
    S_DRAIN,
    S_NEXT,
    S_DONE
  } state_t;

  // A window starting at column j ends at column j+2; the chain needs lat
  // further advances before that sum reaches the end of the chain.
  function automatic int due_step(input int j, input int lat);
    return j + 2 + lat;
  endfunction

endpackage

// File: rtl/conv1_skew_line.sv
// ----------------------------------------------------------------------------
// conv1_skew_line
// Delay line of DEPTH registers that shifts only when en is high. Used to
// skew ifmap rows 1 and 2 so each PE sees its row one advance later than the
// PE before it.
//   clk, rst : clock, synchronous active-high reset
//   clr      : synchronous clear (between rows / outside streaming)
//   en       : shift strobe (one chain advance)
//   din/dout : byte in / byte delayed by DEPTH advances
// ----------------------------------------------------------------------------
module conv1_skew_line #(
  parameter int DEPTH = 1,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout
);

  logic [DW-1:0] pipe [DEPTH];

  // NOTE: state is written with <= so every stage samples the pre-edge value
  // of its neighbour; blocking here would collapse the delay to one stage.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      // NOTE: this array is a handful of flops, not a RAM, and a freshly
      // started row must see zeros, so every entry is cleared explicitly.
      for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
    end else if (en) begin
      pipe[0] <= din;
      for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign dout = pipe[DEPTH-1];

endmodule

// File: rtl/conv1_pe_chain_sched.sv
// ----------------------------------------------------------------------------
// conv1_pe_chain_sched
// Sequencer for the three-PE conv1 chain (PE r handles kernel row r).
// Loads a 3x3 kernel, streams ifmap columns into the chain with per-PE skew,
// stalls the whole chain under output back-pressure and returns the psum of
// the last PE as a valid/ready result stream (W-2 results per output row).
//   start/cfg_*         : job start pulse and configuration (captured in IDLE)
//   busy/done           : job in flight / one-cycle completion pulse
//   wgt_*               : three kernel-row beats, {w2,w1,w0} per beat
//   pix_*               : ifmap column stream, {row2,row1,row0}
//   pe_*                : PE chain control, kernel rows, skewed pixels, psum
//   out_*               : result stream, out_last on the final result of a row
// ----------------------------------------------------------------------------
module conv1_pe_chain_sched
  import conv1_pkg::*;
#(
  parameter int WW  = 8,
  parameter int HW  = 8,
  parameter int LAT = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [WW-1:0]            cfg_width,
  input  logic [HW-1:0]            cfg_rows,
  input  logic                     cfg_relu,
  output logic                     busy,
  output logic                     done,
  input  logic                     wgt_valid,
  output logic                     wgt_ready,
  input  logic [KROW_W-1:0]        wgt_data,
  input  logic                     pix_valid,
  output logic                     pix_ready,
  input  logic [KROW_W-1:0]        pix_data,
  output logic                     pe_rst_n,
  output logic                     pe_en,
  output logic [KROW_W-1:0]        pe_filtr0,
  output logic [KROW_W-1:0]        pe_filtr1,
  output logic [KROW_W-1:0]        pe_filtr2,
  output logic [PIX_W-1:0]         pe_ifmap0,
  output logic [PIX_W-1:0]         pe_ifmap1,
  output logic [PIX_W-1:0]         pe_ifmap2,
  input  logic signed [PSUM_W-1:0] pe_psum,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [PSUM_W-1:0] out_data,
  output logic                     out_last
);

  // Column counter must reach W-1+LAT.
  localparam int CW = WW + $clog2(LAT + 1);

  state_t               state, state_nxt;
  logic [WW-1:0]        width_q;
  logic [HW-1:0]        rows_q;
  logic [HW-1:0]        rows_done;
  logic                 relu_q;
  logic [KROW_W-1:0]    kreg [KROWS];
  logic [1:0]           wgt_cnt;
  logic [CW-1:0]        col;

  logic                 in_run, in_drain;
  logic                 src_ok, advance, out_free;
  logic                 res_due, res_last, last_row;
  logic                 skew_clr;
  logic [PIX_W-1:0]     row1_in, row2_in;
  int                   col_i, w_i;

  assign col_i    = int'(col);
  assign w_i      = int'(width_q);

  assign in_run   = (state == S_RUN);
  assign in_drain = (state == S_DRAIN);
  assign out_free = !out_valid || out_ready;
  // Drain steps need no source: the chain is flushed with zero bytes.
  assign src_ok   = (in_run && pix_valid) || in_drain;
  assign advance  = src_ok && out_free;

  // Results are sampled only at their due step, so stale PE contents from the
  // previous row (or drain zeros) never reach the output.
  assign res_due  = (col_i >= due_step(0, LAT)) && (col_i <= due_step(w_i - 3, LAT));
  assign res_last = (col_i == due_step(w_i - 3, LAT));
  assign last_row = (int'(rows_done) + 1) >= int'(rows_q);

  assign busy      = (state != S_IDLE);
  assign wgt_ready = (state == S_LOAD_W);
  assign pix_ready = in_run && out_free;
  assign pe_en     = advance;
  assign pe_rst_n  = ~rst;

  assign pe_filtr0 = kreg[0];
  assign pe_filtr1 = kreg[1];
  assign pe_filtr2 = kreg[2];

  // ---------------------------------------------------------------- skew
  assign pe_ifmap0 = in_run ? pix_data[0*PIX_W +: PIX_W] : '0;
  assign row1_in   = in_run ? pix_data[1*PIX_W +: PIX_W] : '0;
  assign row2_in   = in_run ? pix_data[2*PIX_W +: PIX_W] : '0;
  assign skew_clr  = !(in_run || in_drain);

  conv1_skew_line #(.DEPTH(1), .DW(PIX_W)) u_skew1 (
    .clk  (clk),
    .rst  (rst),
    .clr  (skew_clr),
    .en   (advance),
    .din  (row1_in),
    .dout (pe_ifmap1)
  );

  conv1_skew_line #(.DEPTH(2), .DW(PIX_W)) u_skew2 (
    .clk  (clk),
    .rst  (rst),
    .clr  (skew_clr),
    .en   (advance),
    .din  (row2_in),
    .dout (pe_ifmap2)
  );

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_nxt = state;
    done      = 1'b0;
    case (state)
      S_IDLE:   if (start) state_nxt = S_LOAD_W;
      S_LOAD_W: if (wgt_valid && wgt_cnt == 2'd2) state_nxt = S_RUN;
      S_RUN:    if (advance && col_i == w_i - 1) state_nxt = S_DRAIN;
      S_DRAIN:  if (advance && col_i == w_i - 1 + LAT) state_nxt = S_NEXT;
      S_NEXT:   state_nxt = last_row ? S_DONE : S_RUN;
      S_DONE: begin
        // Finish once the final result has left (or is leaving this cycle).
        if (out_free) begin
          done      = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default:  state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      width_q   <= '0;
      rows_q    <= '0;
      relu_q    <= 1'b0;
      wgt_cnt   <= '0;
      col       <= '0;
      rows_done <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      for (int k = 0; k < KROWS; k++) kreg[k] <= '0;
    end else begin
      if (state == S_IDLE && start) begin
        width_q   <= cfg_width;
        rows_q    <= cfg_rows;
        relu_q    <= cfg_relu;
        wgt_cnt   <= '0;
        col       <= '0;
        rows_done <= '0;
      end

      if (state == S_LOAD_W && wgt_valid) begin
        kreg[wgt_cnt] <= wgt_data;
        wgt_cnt       <= wgt_cnt + 2'd1;
      end

      // The kernel is kept across rows; only the column position restarts.
      if (state == S_NEXT) begin
        col <= '0;
        if (!last_row) rows_done <= rows_done + 1'b1;
      end else if (advance) begin
        col <= col + 1'b1;
      end

      // advance implies the output slot is free, so a load never overwrites
      // an unaccepted result.
      if (advance && res_due) begin
        out_valid <= 1'b1;
        out_data  <= (relu_q && pe_psum[PSUM_W-1]) ? '0 : pe_psum;
        out_last  <= res_last;
      end else if (out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

endmodule
